// File: rtl/safecrack_param_fsm_if.sv
// Button/code inputs and LED/status outputs of the combination-lock controller.
// The master drives the buttons and expected code; the slave (the lock) drives the indicators.
interface safecrack_param_fsm_if #(
    parameter int NUM_BTN   = 3,
    parameter int CODE_LEN  = 3,
    parameter int GREEN_W   = 8,
    parameter int RED_W     = 18,
    parameter int MAX_FAILS = 3
);
    localparam int BW = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;
    localparam int FW = $clog2(MAX_FAILS + 1);

    logic [NUM_BTN-1:0]     btn;
    logic [CODE_LEN*BW-1:0] code;
    logic [GREEN_W-1:0]     leds_green;
    logic [RED_W-1:0]       leds_red;
    logic                   unlocked;
    logic                   locked_out;
    logic [FW-1:0]          fail_cnt;

    modport master (
        output btn, code,
        input  leds_green, leds_red, unlocked, locked_out, fail_cnt
    );

    modport slave (
        input  btn, code,
        output leds_green, leds_red, unlocked, locked_out, fail_cnt
    );
endinterface

// File: rtl/safecrack_param_fsm.sv
// Parameterised combination lock: digit entry, timed error/open/lockout displays,
// consecutive-failure lockout, and an inactivity abort during partial entry.
module safecrack_param_fsm #(
    parameter int NUM_BTN     = 3,
    parameter int CODE_LEN    = 3,
    parameter int GREEN_W     = 8,
    parameter int RED_W       = 18,
    parameter int ERR_CYCLES  = 150_000_000,
    parameter int OPEN_CYCLES = 250_000_000,
    parameter int MAX_FAILS   = 3,
    parameter int LOCK_CYCLES = 500_000_000,
    parameter int IDLE_CYCLES = 500_000_000
) (
    input  logic                 clk,
    input  logic                 rstn,
    safecrack_param_fsm_if.slave bus
);
    localparam int BW    = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;
    localparam int FW    = $clog2(MAX_FAILS + 1);
    localparam int IW    = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam int MAX_A = (ERR_CYCLES > OPEN_CYCLES) ? ERR_CYCLES : OPEN_CYCLES;
    localparam int MAX_B = (LOCK_CYCLES > IDLE_CYCLES) ? LOCK_CYCLES : IDLE_CYCLES;
    localparam int MAX_D = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAX_D + 1);

    // Loaded value is length-1 so the state is held for exactly "length" cycles.
    localparam logic [CW-1:0] ERR_LD  = CW'(ERR_CYCLES - 1);
    localparam logic [CW-1:0] OPEN_LD = CW'(OPEN_CYCLES - 1);
    localparam logic [CW-1:0] LOCK_LD = CW'(LOCK_CYCLES - 1);
    localparam logic [CW-1:0] IDLE_LD = CW'(IDLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_ENTRY   = 2'd0,
        ST_ERROR   = 2'd1,
        ST_OPEN    = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [FW-1:0]      fail_q, fail_d;
    logic [NUM_BTN-1:0] pos_q, prev_q;

    logic [NUM_BTN-1:0] evt;
    logic               any_evt;
    logic               one_evt;
    logic [BW-1:0]      digit;
    logic [BW-1:0]      code_digit;
    logic               last_digit;
    logic               idx_bad;
    logic [FW-1:0]      fail_inc;
    logic [GREEN_W-1:0] therm;

    // Buttons are tracked in every state so a press held into ENTRY never fires.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pos_q  <= '0;
            prev_q <= '0;
        end else begin
            pos_q  <= ~bus.btn;
            prev_q <= pos_q;
        end
    end

    assign evt     = pos_q & ~prev_q;
    assign any_evt = |evt;
    assign one_evt = $onehot(evt);

    always_comb begin
        digit = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (evt[i]) begin
                digit = BW'(i);
            end
        end
    end

    assign code_digit = bus.code[32'(idx_q) * BW +: BW];
    assign last_digit = (32'(idx_q) == CODE_LEN - 1);
    assign idx_bad    = (32'(idx_q) > CODE_LEN - 1);
    assign fail_inc   = fail_q + FW'(1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_ENTRY;
            idx_q   <= '0;
            cnt_q   <= '0;
            fail_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            fail_q  <= fail_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        fail_d  = fail_q;
        case (state_q)
            ST_ENTRY: begin
                if (idx_bad) begin
                    idx_d = '0;
                    cnt_d = IDLE_LD;
                end else if (any_evt) begin
                    if (one_evt && (digit == code_digit)) begin
                        if (last_digit) begin
                            state_d = ST_OPEN;
                            idx_d   = '0;
                            cnt_d   = OPEN_LD;
                            fail_d  = '0;
                        end else begin
                            idx_d = idx_q + IW'(1);
                            cnt_d = IDLE_LD;
                        end
                    end else begin
                        fail_d = fail_inc;
                        idx_d  = '0;
                        if (fail_inc == FW'(MAX_FAILS)) begin
                            state_d = ST_LOCKOUT;
                            cnt_d   = LOCK_LD;
                        end else begin
                            state_d = ST_ERROR;
                            cnt_d   = ERR_LD;
                        end
                    end
                end else if (idx_q != '0) begin
                    // Inactivity abort only once entry has started.
                    if (cnt_q == '0) begin
                        idx_d = '0;
                        cnt_d = IDLE_LD;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            ST_ERROR, ST_OPEN, ST_LOCKOUT: begin
                if (cnt_q == '0) begin
                    state_d = ST_ENTRY;
                    idx_d   = '0;
                    cnt_d   = IDLE_LD;
                    if (state_q == ST_LOCKOUT) begin
                        fail_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = ST_ENTRY;
                idx_d   = '0;
                cnt_d   = IDLE_LD;
            end
        endcase
    end

    for (genvar gi = 0; gi < GREEN_W; gi++) begin : g_therm
        assign therm[gi] = (gi <= 32'(idx_q));
    end

    always_comb begin
        bus.leds_green = '0;
        bus.leds_red   = '0;
        bus.unlocked   = 1'b0;
        bus.locked_out = 1'b0;
        case (state_q)
            ST_ENTRY:   bus.leds_green = therm;
            ST_ERROR:   bus.leds_red[0] = 1'b1;
            ST_OPEN: begin
                bus.leds_green = '1;
                bus.unlocked   = 1'b1;
            end
            ST_LOCKOUT: begin
                bus.leds_red   = '1;
                bus.locked_out = 1'b1;
            end
            default: bus.leds_green = '0;
        endcase
    end

    assign bus.fail_cnt = fail_q;
endmodule

// File: tb/tb_safecrack_param_fsm.sv
// Directed scenarios plus a randomized run against a behavioural lock model.
module tb_safecrack_param_fsm;
    localparam int NUM_BTN  = 3;
    localparam int CODE_LEN = 3;
    localparam int GREEN_W  = 8;
    localparam int RED_W    = 18;
    localparam int ERR_C    = 5;
    localparam int OPEN_C   = 8;
    localparam int LOCK_C   = 12;
    localparam int MAX_F    = 2;
    localparam int IDLE_C   = 20;

    logic clk = 1'b0;
    logic rstn;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   code_d [CODE_LEN] = '{0, 1, 2};

    always #5 clk = ~clk;

    safecrack_param_fsm_if #(
        .NUM_BTN(NUM_BTN), .CODE_LEN(CODE_LEN), .GREEN_W(GREEN_W),
        .RED_W(RED_W), .MAX_FAILS(MAX_F)
    ) bus ();

    safecrack_param_fsm #(
        .NUM_BTN(NUM_BTN), .CODE_LEN(CODE_LEN), .GREEN_W(GREEN_W), .RED_W(RED_W),
        .ERR_CYCLES(ERR_C), .OPEN_CYCLES(OPEN_C), .MAX_FAILS(MAX_F),
        .LOCK_CYCLES(LOCK_C), .IDLE_CYCLES(IDLE_C)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mask: 1 = pressed; held for one cycle, result visible on return.
    task automatic press(input logic [NUM_BTN-1:0] mask);
        bus.btn = ~mask;
        tick();
        bus.btn = '1;
        tick();
    endtask

    task automatic apply_reset();
        rstn    = 1'b0;
        bus.btn = '1;
        tick();
        tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rstn    = 1'b0;
        bus.btn = '1;
        #1;
        n_checks++;
        if (bus.leds_green !== 8'h01) begin n_fail++; $display("FAIL reset_green: got %h expected 01", bus.leds_green); end
        n_checks++;
        if (bus.leds_red !== 18'h0) begin n_fail++; $display("FAIL reset_red: got %h expected 0", bus.leds_red); end
        n_checks++;
        if (bus.unlocked !== 1'b0 || bus.locked_out !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: unlocked=%b locked_out=%b expected 0 0", bus.unlocked, bus.locked_out);
        end
        n_checks++;
        if (bus.fail_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_fail_cnt: got %0d expected 0", bus.fail_cnt); end
        tick();
        tick();
        rstn = 1'b1;
        tick();
        n_checks++;
        if (bus.leds_green !== 8'h01) begin n_fail++; $display("FAIL reset_release_green: got %h expected 01", bus.leds_green); end
        $display("test_reset done");
    endtask

    task automatic test_unlock();
        int n;
        apply_reset();
        n_checks++;
        if (bus.leds_green !== 8'h01) begin n_fail++; $display("FAIL unlock_start: got %h expected 01", bus.leds_green); end
        press(3'b001);
        n_checks++;
        if (bus.leds_green !== 8'h03) begin n_fail++; $display("FAIL unlock_d0: got %h expected 03", bus.leds_green); end
        press(3'b010);
        n_checks++;
        if (bus.leds_green !== 8'h07) begin n_fail++; $display("FAIL unlock_d1: got %h expected 07", bus.leds_green); end
        press(3'b100);
        n_checks++;
        if (bus.leds_green !== 8'hFF || bus.unlocked !== 1'b1) begin
            n_fail++; $display("FAIL unlock_open: green=%h unlocked=%b expected ff 1", bus.leds_green, bus.unlocked);
        end
        n = 0;
        while (bus.unlocked === 1'b1 && n < 100) begin n++; tick(); end
        n_checks++;
        if (n != OPEN_C) begin n_fail++; $display("FAIL unlock_len: got %0d cycles expected %0d", n, OPEN_C); end
        n_checks++;
        if (bus.leds_green !== 8'h01 || bus.fail_cnt !== 2'd0) begin
            n_fail++; $display("FAIL unlock_end: green=%h fail_cnt=%0d expected 01 0", bus.leds_green, bus.fail_cnt);
        end
        $display("test_unlock done: open for %0d cycles", n);
    endtask

    task automatic test_wrong_digit();
        int n;
        apply_reset();
        press(3'b001);
        press(3'b100);
        n_checks++;
        if (bus.leds_red !== 18'h1 || bus.leds_green !== 8'h00) begin
            n_fail++; $display("FAIL wrong_error: red=%h green=%h expected 1 00", bus.leds_red, bus.leds_green);
        end
        n_checks++;
        if (bus.fail_cnt !== 2'd1) begin n_fail++; $display("FAIL wrong_fail_cnt: got %0d expected 1", bus.fail_cnt); end
        n = 0;
        while (bus.leds_red[0] === 1'b1 && n < 100) begin n++; tick(); end
        n_checks++;
        if (n != ERR_C) begin n_fail++; $display("FAIL wrong_len: got %0d cycles expected %0d", n, ERR_C); end
        n_checks++;
        if (bus.leds_green !== 8'h01 || bus.fail_cnt !== 2'd1) begin
            n_fail++; $display("FAIL wrong_end: green=%h fail_cnt=%0d expected 01 1", bus.leds_green, bus.fail_cnt);
        end
        $display("test_wrong_digit done: error for %0d cycles", n);
    endtask

    task automatic test_lockout();
        int n;
        apply_reset();
        press(3'b010);
        n = 0;
        while (bus.leds_red[0] === 1'b1 && n < 100) begin n++; tick(); end
        press(3'b100);
        n_checks++;
        if (bus.locked_out !== 1'b1 || bus.leds_red !== 18'h3FFFF || bus.fail_cnt !== 2'd2) begin
            n_fail++; $display("FAIL lock_enter: locked_out=%b red=%h fail_cnt=%0d expected 1 3ffff 2",
                               bus.locked_out, bus.leds_red, bus.fail_cnt);
        end
        n = 0;
        while (bus.locked_out === 1'b1 && n < 100) begin
            n++;
            bus.btn = (n >= 3 && n < 6) ? 3'b110 : 3'b111;
            tick();
        end
        bus.btn = '1;
        n_checks++;
        if (n != LOCK_C) begin n_fail++; $display("FAIL lock_len: got %0d cycles expected %0d", n, LOCK_C); end
        n_checks++;
        if (bus.fail_cnt !== 2'd0 || bus.leds_green !== 8'h01) begin
            n_fail++; $display("FAIL lock_end: fail_cnt=%0d green=%h expected 0 01", bus.fail_cnt, bus.leds_green);
        end
        tick();
        n_checks++;
        if (bus.leds_green !== 8'h01) begin n_fail++; $display("FAIL lock_after: got %h expected 01", bus.leds_green); end
        $display("test_lockout done: lockout for %0d cycles", n);
    endtask

    task automatic test_idle();
        int n;
        apply_reset();
        press(3'b100);
        n = 0;
        while (bus.leds_red[0] === 1'b1 && n < 100) begin n++; tick(); end
        press(3'b001);
        n_checks++;
        if (bus.leds_green !== 8'h03) begin n_fail++; $display("FAIL idle_start: got %h expected 03", bus.leds_green); end
        repeat (IDLE_C - 1) tick();
        n_checks++;
        if (bus.leds_green !== 8'h03) begin n_fail++; $display("FAIL idle_early: got %h expected 03", bus.leds_green); end
        tick();
        n_checks++;
        if (bus.leds_green !== 8'h01 || bus.fail_cnt !== 2'd1) begin
            n_fail++; $display("FAIL idle_abort: green=%h fail_cnt=%0d expected 01 1", bus.leds_green, bus.fail_cnt);
        end
        $display("test_idle done");
    endtask

    task automatic test_multi_press();
        int n;
        apply_reset();
        bus.btn = 3'b100;
        tick();
        tick();
        n_checks++;
        if (bus.leds_red !== 18'h1 || bus.fail_cnt !== 2'd1) begin
            n_fail++; $display("FAIL multi_error: red=%h fail_cnt=%0d expected 1 1", bus.leds_red, bus.fail_cnt);
        end
        n = 0;
        while (bus.leds_red[0] === 1'b1 && n < 100) begin n++; tick(); end
        n_checks++;
        if (n != ERR_C) begin n_fail++; $display("FAIL multi_len: got %0d cycles expected %0d", n, ERR_C); end
        repeat (3) tick();
        n_checks++;
        if (bus.leds_green !== 8'h01 || bus.fail_cnt !== 2'd1) begin
            n_fail++; $display("FAIL multi_held: green=%h fail_cnt=%0d expected 01 1", bus.leds_green, bus.fail_cnt);
        end
        bus.btn = '1;
        tick();
        tick();
        n_checks++;
        if (bus.leds_green !== 8'h01) begin n_fail++; $display("FAIL multi_release: got %h expected 01", bus.leds_green); end
        $display("test_multi_press done");
    endtask

    task automatic test_reset_mid_open();
        apply_reset();
        press(3'b001);
        press(3'b010);
        press(3'b100);
        tick();
        tick();
        n_checks++;
        if (bus.unlocked !== 1'b1) begin n_fail++; $display("FAIL midopen_pre: unlocked=%b expected 1", bus.unlocked); end
        rstn = 1'b0;
        #1;
        n_checks++;
        if (bus.unlocked !== 1'b0 || bus.leds_green !== 8'h01) begin
            n_fail++; $display("FAIL midopen_reset: unlocked=%b green=%h expected 0 01", bus.unlocked, bus.leds_green);
        end
        tick();
        rstn = 1'b1;
        tick();
        $display("test_reset_mid_open done");
    endtask

    // Model: mode 0=entry 1=error 2=open 3=lockout; 'left' counts remaining timed cycles.
    task automatic test_random();
        int mode, idx, left, idle, fails, r, k, dig, opens, locks;
        logic [NUM_BTN-1:0] cur, prev, evt, b;
        logic [GREEN_W-1:0] exp_g;
        logic [RED_W-1:0]   exp_r;
        apply_reset();
        mode = 0; idx = 0; left = 0; idle = 0; fails = 0; opens = 0; locks = 0;
        cur = '0; prev = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            r = $urandom_range(0, 9);
            if (r < 5)       b = '0;
            else if (r < 8)  b = 3'(1 << code_d[idx]);
            else if (r == 8) b = 3'(1 << $urandom_range(0, NUM_BTN - 1));
            else             b = 3'($urandom_range(0, 7));
            bus.btn = ~b;

            evt = cur & ~prev;
            if (mode == 0) begin
                if (evt != '0) begin
                    dig = -1;
                    for (int i = 0; i < NUM_BTN; i++) if (evt[i]) dig = i;
                    if ($countones(evt) == 1 && dig == code_d[idx]) begin
                        if (idx == CODE_LEN - 1) begin
                            mode = 2; left = OPEN_C; idx = 0; fails = 0; opens++;
                        end else begin
                            idx++; idle = 0;
                        end
                    end else begin
                        fails++; idx = 0;
                        if (fails == MAX_F) begin mode = 3; left = LOCK_C; locks++; end
                        else begin mode = 1; left = ERR_C; end
                    end
                end else if (idx > 0) begin
                    idle++;
                    if (idle == IDLE_C) idx = 0;
                end
            end else begin
                left--;
                if (left == 0) begin
                    if (mode == 3) fails = 0;
                    mode = 0; idx = 0;
                end
            end
            prev = cur;
            cur  = b;

            tick();
            exp_g = (mode == 0) ? GREEN_W'((1 << (idx + 1)) - 1) : (mode == 2) ? '1 : '0;
            exp_r = (mode == 1) ? RED_W'(1) : (mode == 3) ? '1 : '0;
            k = 0;
            n_checks++;
            if (bus.leds_green !== exp_g) begin n_fail++; $display("FAIL rand_green cyc %0d: got %h expected %h", cyc, bus.leds_green, exp_g); end
            n_checks++;
            if (bus.leds_red !== exp_r) begin n_fail++; $display("FAIL rand_red cyc %0d: got %h expected %h", cyc, bus.leds_red, exp_r); end
            n_checks++;
            if (bus.unlocked !== (mode == 2) || bus.locked_out !== (mode == 3)) begin
                n_fail++; $display("FAIL rand_flags cyc %0d: unlocked=%b locked_out=%b expected %b %b",
                                   cyc, bus.unlocked, bus.locked_out, mode == 2, mode == 3);
            end
            n_checks++;
            if (bus.fail_cnt !== 2'(fails)) begin n_fail++; $display("FAIL rand_fail_cnt cyc %0d: got %0d expected %0d", cyc, bus.fail_cnt, fails); end
        end
        bus.btn = '1;
        $display("test_random done: %0d opens, %0d lockouts", opens, locks);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.btn  = '1;
        bus.code = {2'd2, 2'd1, 2'd0};
        rstn     = 1'b1;
        test_reset();
        test_unlock();
        test_wrong_digit();
        test_lockout();
        test_idle();
        test_multi_press();
        test_reset_mid_open();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/safecrack_param_fsm.md
SAFECRACK_PARAM_FSM -- requirements
Module: safecrack_param_fsm

Interface
REQ-001 Parameter NUM_BTN, default 3: number of push-buttons (2..8).
REQ-002 Parameter CODE_LEN, default 3: digits per code (1..7).
REQ-003 Parameter GREEN_W, default 8: green LED count; GREEN_W SHALL exceed CODE_LEN.
REQ-004 Parameter RED_W, default 18: red LED count (>=2).
REQ-005 Parameter ERR_CYCLES, default 150_000_000: error display length (3 s at 50 MHz).
REQ-006 Parameter OPEN_CYCLES, default 250_000_000: unlocked display length (5 s).
REQ-007 Parameter MAX_FAILS, default 3: consecutive failures that trigger lockout (>=1).
REQ-008 Parameter LOCK_CYCLES, default 500_000_000: lockout length (10 s).
REQ-009 Parameter IDLE_CYCLES, default 500_000_000: inactivity abort mid-entry (10 s).
REQ-010 clk  in  1  system clock.
REQ-011 rstn  in  1  reset; asynchronous, active-low.
REQ-012 btn  in  NUM_BTN  raw buttons, active-low (pressed = 0), already synchronised and debounced.
REQ-013 code  in  CODE_LEN*BW  expected code, BW = clog2(NUM_BTN); digit k in bits [k*BW +: BW]; digit 0 entered first; held static.
REQ-014 leds_green  out  GREEN_W  progress / open indication.
REQ-015 leds_red  out  RED_W  error / lockout indication.
REQ-016 unlocked  out  1  high while the safe is open.
REQ-017 locked_out  out  1  high during lockout.
REQ-018 fail_cnt  out  clog2(MAX_FAILS+1)  consecutive failure count.

Function
REQ-019 The block SHALL invert btn, register it, and form press events as pos & ~prev (0->1 of the inverted value); one event per press.
REQ-020 A valid digit SHALL be a cycle with exactly one press event; its value is the index of that bit.
REQ-021 A cycle with two or more press events SHALL count as a wrong digit.
REQ-022 States: ENTRY (digit index idx 0..CODE_LEN-1), ERROR, OPEN, LOCKOUT.
REQ-023 In ENTRY, a valid digit equal to code digit idx SHALL advance idx by 1 in the next cycle; on the last digit the next state is OPEN and fail_cnt clears to 0.
REQ-024 In ENTRY, a wrong digit SHALL increment fail_cnt; if the new count equals MAX_FAILS the next state is LOCKOUT, otherwise ERROR.
REQ-025 In ENTRY with idx>0, IDLE_CYCLES consecutive cycles with no press event SHALL return to ENTRY idx 0 without changing fail_cnt; no timeout applies at idx 0.
REQ-026 ERROR, OPEN and LOCKOUT SHALL each last exactly ERR_CYCLES, OPEN_CYCLES and LOCK_CYCLES cycles respectively, then go to ENTRY idx 0; presses are ignored there.
REQ-027 On leaving LOCKOUT, fail_cnt SHALL clear to 0.
REQ-028 One shared down-counter SHALL time all delays; it is loaded on every state entry and on every accepted digit.
REQ-029 The counter width SHALL fit the largest delay parameter.
REQ-030 Button state SHALL keep being registered in every state, so that a press held across a return to ENTRY raises no event.
REQ-031 leds_green in ENTRY SHALL be a thermometer of idx+1 ones from bit 0; all ones in OPEN; all zeros in ERROR and LOCKOUT.
REQ-032 leds_red[0] SHALL be high in ERROR and LOCKOUT; leds_red[RED_W-1:1] all high only in LOCKOUT; otherwise zero.
REQ-033 unlocked = (state==OPEN); locked_out = (state==LOCKOUT); all outputs are registered-state decodes with no input-to-output combinational path.
REQ-034 Unreachable encodings SHALL recover to ENTRY idx 0.

Reset
REQ-035 While rstn is low: state ENTRY idx 0, counter 0, fail_cnt 0, button register 0 (all released); leds_green = 1, leds_red = 0, unlocked = 0, locked_out = 0.
REQ-036 Reset asserted mid-ERROR, mid-OPEN or mid-LOCKOUT SHALL abort the delay immediately.

Verification
Bench parameters: NUM_BTN=3, CODE_LEN=3, code={2,1,0}, ERR=5, OPEN=8, LOCK=12, MAX_FAILS=2, IDLE=20.
REQ-037 Press btn0, btn1, btn2 in sequence -> leds_green 001, 011, 111, then 0xFF with unlocked=1 for exactly 8 cycles, then 001.
REQ-038 Press btn0, then btn2 -> leds_red[0]=1 and fail_cnt=1 for 5 cycles, then leds_green=001.
REQ-039 Two consecutive wrong digits -> fail_cnt=2, locked_out=1, leds_red all ones for 12 cycles, presses ignored, then fail_cnt=0 and leds_green=001.
REQ-040 Press btn0, then wait 20 idle cycles -> leds_green 011 returns to 001, fail_cnt unchanged.
REQ-041 Press btn0 and btn1 together at idx 0 -> ERROR; a press held through the end of ERROR -> no event.
REQ-042 Drop rstn at cycle 3 of OPEN -> unlocked=0 and leds_green=001 immediately.
